h75_frame_scheduler: RTL and testbench

- Sequences the HUB75 timing generator.
- Gates its gen_timing request and computes the six BCM plane on-times from a host brightness value.
- Swaps the display/write frame-buffer banks, and applies new brightness, only at frame boundaries (rising edge of frame_sync), so a frame is never torn.
- Sits between the host register interface and the timing generator / frame memory.

---
 rtl/h75_frame_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_h75_frame_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/h75_frame_scheduler.sv
// HUB75 frame scheduler: gates the timing generator, derives BCM plane on-times from brightness,
// and defers bank swaps / brightness changes to frame boundaries. Optional macro: H75_FRAME_COUNTER_EN.
module h75_frame_scheduler #(
    parameter logic [13:0] BCM_UNIT      = 14'd400,
    parameter logic [23:0] FRAME_TIMEOUT = 24'd2000000,
    parameter logic [23:0] DRAIN_CYCLES  = 24'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  cfg_brightness,
    input  logic        swap_req,
    output logic        swap_ack,
    input  logic        frame_sync,
    output logic        gen_timing,
    output logic        display_bank,
    output logic        write_bank,
    output logic [13:0] bcm_count_0,
    output logic [13:0] bcm_count_1,
    output logic [13:0] bcm_count_2,
    output logic [13:0] bcm_count_3,
    output logic [13:0] bcm_count_4,
    output logic [13:0] bcm_count_5,
    output logic        busy,
    output logic        frame_err
`ifdef H75_FRAME_COUNTER_EN
    ,
    output logic [15:0] frame_count
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, RUN, DRAIN} state_t;

    state_t      state_reg;
    logic        frame_sync_d_reg;
    logic [7:0]  brightness_reg;
    logic        busy_reg;
    logic [2:0]  calc_cnt_reg;
    logic [13:0] base_reg;
    logic        cfg_pending_reg;
    logic        cfg_ready_reg;
    logic        swap_pending_reg;
    logic        swap_ack_reg;
    logic        display_bank_reg;
    logic        gen_timing_reg;
    logic        frame_err_reg;
    logic [23:0] timeout_cnt_reg;
    logic [23:0] drain_cnt_reg;
    logic [21:0] product;
    logic [6*14-1:0] bcm_flat;

    logic boundary, cfg_accept, calc_start, calc_done, apply, swap_now;

    assign boundary   = frame_sync & ~frame_sync_d_reg;
    assign cfg_accept = cfg_valid & cfg_ready_reg;
    assign calc_start = cfg_accept | ((state_reg == IDLE) & enable);
    assign calc_done  = busy_reg & (calc_cnt_reg == 3'd6);
    // Outside RUN the counts may change immediately; in RUN only at a frame boundary.
    assign apply      = cfg_pending_reg & ((state_reg == IDLE) | (state_reg == CALC) |
                                           ((state_reg == RUN) & boundary));
    assign swap_now   = (state_reg == RUN) & boundary & (swap_pending_reg | swap_req);
    assign product    = 22'(brightness_reg) * 22'(BCM_UNIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            frame_sync_d_reg <= 1'b0;
            brightness_reg   <= 8'hFF;
            busy_reg         <= 1'b0;
            calc_cnt_reg     <= 3'd0;
            base_reg         <= 14'd0;
            cfg_pending_reg  <= 1'b0;
            cfg_ready_reg    <= 1'b1;
            swap_pending_reg <= 1'b0;
            swap_ack_reg     <= 1'b0;
            display_bank_reg <= 1'b0;
            gen_timing_reg   <= 1'b0;
            frame_err_reg    <= 1'b0;
            timeout_cnt_reg  <= 24'd0;
            drain_cnt_reg    <= 24'd0;
        end else begin
            frame_sync_d_reg <= frame_sync;
            swap_ack_reg     <= 1'b0;

            if (swap_req)
                swap_pending_reg <= 1'b1;
            if (swap_now) begin
                display_bank_reg <= ~display_bank_reg;
                swap_ack_reg     <= 1'b1;
                swap_pending_reg <= 1'b0;
            end

            if (apply) begin
                cfg_pending_reg <= 1'b0;
                cfg_ready_reg   <= 1'b1;
            end
            if (calc_done) begin
                cfg_pending_reg <= 1'b1;
                busy_reg        <= 1'b0;
            end
            if (cfg_accept)
                brightness_reg <= cfg_brightness;
            // A fresh start aborts any calculation in flight and discards its result.
            if (calc_start) begin
                busy_reg        <= 1'b1;
                calc_cnt_reg    <= 3'd0;
                cfg_ready_reg   <= 1'b0;
                cfg_pending_reg <= 1'b0;
            end else if (busy_reg) begin
                calc_cnt_reg <= calc_cnt_reg + 3'd1;
            end
            if (busy_reg && calc_cnt_reg == 3'd0)
                base_reg <= 14'(product >> 8);

            case (state_reg)
                IDLE: begin
                    gen_timing_reg <= 1'b0;
                    if (enable)
                        state_reg <= CALC;
                end
                CALC: begin
                    if (apply) begin
                        state_reg       <= enable ? RUN : IDLE;
                        gen_timing_reg  <= enable;
                        timeout_cnt_reg <= 24'd0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_reg      <= DRAIN;
                        gen_timing_reg <= 1'b0;
                        drain_cnt_reg  <= 24'd0;
                    end else if (boundary) begin
                        timeout_cnt_reg <= 24'd0;
                    end else if (timeout_cnt_reg != FRAME_TIMEOUT) begin
                        timeout_cnt_reg <= timeout_cnt_reg + 24'd1;
                        if (timeout_cnt_reg + 24'd1 == FRAME_TIMEOUT)
                            frame_err_reg <= 1'b1;
                    end
                end
                DRAIN: begin
                    gen_timing_reg <= 1'b0;
                    if (drain_cnt_reg == DRAIN_CYCLES - 24'd1)
                        state_reg <= IDLE;
                    else
                        drain_cnt_reg <= drain_cnt_reg + 24'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // One shadow/live pair per BCM plane; plane gi is computed in calc cycle gi+1.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : gen_plane
            logic [13:0] shadow_reg;
            logic [13:0] bcm_reg;
            logic [19:0] shifted;

            assign shifted = {6'b0, base_reg} << gi;

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg <= 14'd0;
                    bcm_reg    <= 14'd0;
                end else begin
                    if (busy_reg && !calc_start && calc_cnt_reg == 3'(gi + 1))
                        shadow_reg <= (|shifted[19:14]) ? 14'h3FFF : shifted[13:0];
                    if (apply)
                        bcm_reg <= shadow_reg;
                end
            end

            assign bcm_flat[gi*14 +: 14] = bcm_reg;
        end
    endgenerate

`ifdef H75_FRAME_COUNTER_EN
    logic [15:0] frame_count_reg;
    always_ff @(posedge clk) begin
        if (reset)
            frame_count_reg <= 16'd0;
        else if (state_reg == RUN && boundary)
            frame_count_reg <= frame_count_reg + 16'd1;
    end
    assign frame_count = frame_count_reg;
`endif

    assign cfg_ready    = cfg_ready_reg;
    assign swap_ack     = swap_ack_reg;
    assign gen_timing   = gen_timing_reg;
    assign display_bank = display_bank_reg;
    assign write_bank   = ~display_bank_reg;
    assign busy         = busy_reg;
    assign frame_err    = frame_err_reg;
    assign bcm_count_0  = bcm_flat[0*14 +: 14];
    assign bcm_count_1  = bcm_flat[1*14 +: 14];
    assign bcm_count_2  = bcm_flat[2*14 +: 14];
    assign bcm_count_3  = bcm_flat[3*14 +: 14];
    assign bcm_count_4  = bcm_flat[4*14 +: 14];
    assign bcm_count_5  = bcm_flat[5*14 +: 14];
endmodule

// File: tb/tb_h75_frame_scheduler.sv
// Directed bench for h75_frame_scheduler: a primary instance (BCM_UNIT 400, short timeout/drain)
// and a second instance with BCM_UNIT 4000 sharing the same stimulus for the saturation case.
module tb_h75_frame_scheduler;
    logic       clk = 1'b0;
    logic       reset, enable, cfg_valid, swap_req, frame_sync;
    logic [7:0] cfg_brightness;

    logic        cfg_ready, swap_ack, gen_timing, display_bank, write_bank, busy, frame_err;
    logic [13:0] cnt [6];
    logic        s_cfg_ready, s_swap_ack, s_gen_timing, s_display_bank, s_write_bank, s_busy, s_frame_err;
    logic [13:0] s_cnt [6];
`ifdef H75_FRAME_COUNTER_EN
    logic [15:0] frame_count, s_frame_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    h75_frame_scheduler #(.BCM_UNIT(14'd400), .FRAME_TIMEOUT(24'd100), .DRAIN_CYCLES(24'd10)) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_brightness(cfg_brightness), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_sync(frame_sync), .gen_timing(gen_timing), .display_bank(display_bank),
        .write_bank(write_bank), .bcm_count_0(cnt[0]), .bcm_count_1(cnt[1]), .bcm_count_2(cnt[2]),
        .bcm_count_3(cnt[3]), .bcm_count_4(cnt[4]), .bcm_count_5(cnt[5]), .busy(busy),
        .frame_err(frame_err)
`ifdef H75_FRAME_COUNTER_EN
        , .frame_count(frame_count)
`endif
    );

    h75_frame_scheduler #(.BCM_UNIT(14'd4000), .FRAME_TIMEOUT(24'd100), .DRAIN_CYCLES(24'd10)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid), .cfg_ready(s_cfg_ready),
        .cfg_brightness(cfg_brightness), .swap_req(swap_req), .swap_ack(s_swap_ack),
        .frame_sync(frame_sync), .gen_timing(s_gen_timing), .display_bank(s_display_bank),
        .write_bank(s_write_bank), .bcm_count_0(s_cnt[0]), .bcm_count_1(s_cnt[1]),
        .bcm_count_2(s_cnt[2]), .bcm_count_3(s_cnt[3]), .bcm_count_4(s_cnt[4]),
        .bcm_count_5(s_cnt[5]), .busy(s_busy), .frame_err(s_frame_err)
`ifdef H75_FRAME_COUNTER_EN
        , .frame_count(s_frame_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
        $display("check %-22s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic chk_counts(input string tag, input logic [13:0] obs [6], input int exp_v [6]);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_cnt%0d", tag, i), 32'(obs[i]), 32'(exp_v[i]));
    endtask

    int e255 [6]  = '{398, 796, 1592, 3184, 6368, 12736};
    int e128 [6]  = '{200, 400, 800, 1600, 3200, 6400};
    int esat [6]  = '{3984, 7968, 15936, 16383, 16383, 16383};
    int ezero [6] = '{0, 0, 0, 0, 0, 0};

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; swap_req = 1'b0;
        frame_sync = 1'b0; cfg_brightness = 8'd0;
        tick(); tick();
        chk("rst_gen_timing", 32'(gen_timing), 0);
        chk("rst_display_bank", 32'(display_bank), 0);
        chk("rst_write_bank", 32'(write_bank), 1);
        chk("rst_swap_ack", 32'(swap_ack), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk_counts("rst", cnt, ezero);
        reset = 1'b0;
        tick();

        // Enable from reset: 7 busy cycles, apply, then RUN.
        enable = 1'b1;
        tick();
        chk("en_busy_first", 32'(busy), 1);
        repeat (6) tick();
        chk("en_busy_last", 32'(busy), 1);
        chk("en_gen_timing_calc", 32'(gen_timing), 0);
        tick();
        chk("en_busy_done", 32'(busy), 0);
        chk("en_cnt0_not_applied", 32'(cnt[0]), 0);
        tick();
        chk_counts("b255", cnt, e255);
        chk_counts("sat", s_cnt, esat);
        chk("en_gen_timing_run", 32'(gen_timing), 1);

        // Brightness 128 mid-frame: held back until the next boundary.
        cfg_valid = 1'b1; cfg_brightness = 8'd128;
        tick();
        cfg_valid = 1'b0;
        chk("cfg_ready_dropped", 32'(cfg_ready), 0);
        repeat (9) tick();
        chk("cfg_hold_cnt0", 32'(cnt[0]), 398);
        chk("cfg_hold_cnt5", 32'(cnt[5]), 12736);
        chk("cfg_ready_hold", 32'(cfg_ready), 0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk_counts("b128", cnt, e128);
        chk("cfg_ready_back", 32'(cfg_ready), 1);
        tick();

        // Three swap requests in one frame produce one swap.
        for (int i = 0; i < 3; i++) begin
            swap_req = 1'b1; tick();
            swap_req = 1'b0; tick();
        end
        chk("swap_wait_ack", 32'(swap_ack), 0);
        chk("swap_wait_bank", 32'(display_bank), 0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("swap1_ack", 32'(swap_ack), 1);
        chk("swap1_display", 32'(display_bank), 1);
        chk("swap1_write", 32'(write_bank), 0);
        tick();
        chk("swap1_ack_pulse", 32'(swap_ack), 0);
        tick();
        frame_sync = 1'b1; swap_req = 1'b1;
        tick();
        frame_sync = 1'b0; swap_req = 1'b0;
        chk("swap2_coincident_ack", 32'(swap_ack), 1);
        chk("swap2_display", 32'(display_bank), 0);
        tick();
        chk("swap2_no_repeat", 32'(swap_ack), 0);

        // Frame timeout after 100 clocks without a boundary.
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        repeat (99) tick();
        chk("timeout_before", 32'(frame_err), 0);
        tick();
        chk("timeout_at", 32'(frame_err), 1);
        frame_sync = 1'b1; tick();
        frame_sync = 1'b0; repeat (3) tick();
        chk("timeout_sticky", 32'(frame_err), 1);

        // Disable with a swap pending; drain ignores boundaries.
        swap_req = 1'b1; tick();
        swap_req = 1'b0;
        enable = 1'b0;
        tick();
        chk("drain_gen_timing", 32'(gen_timing), 0);
        frame_sync = 1'b1; tick();
        frame_sync = 1'b0; tick();
        chk("drain_no_swap_ack", 32'(swap_ack), 0);
        chk("drain_no_swap_bank", 32'(display_bank), 0);
        repeat (3) tick();
        enable = 1'b1;
        repeat (5) tick();
        chk("drain_still_idle", 32'(busy), 0);
        tick();
        chk("reenable_busy", 32'(busy), 1);
        repeat (8) tick();
        chk("reenable_run", 32'(gen_timing), 1);
        chk("reenable_bank_held", 32'(display_bank), 0);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("reenable_swap_ack", 32'(swap_ack), 1);
        chk("reenable_swap_bank", 32'(display_bank), 1);
        chk_counts("reenable", cnt, e128);
        tick();

        // Reset in the middle of a calculation.
        enable = 1'b0;
        tick();
        repeat (10) tick();
        enable = 1'b1;
        tick();
        chk("calc_busy_prereset", 32'(busy), 1);
        tick(); tick();
        chk("cnt0_prereset", 32'(cnt[0]), 200);
        reset = 1'b1;
        tick();
        chk("midcalc_busy", 32'(busy), 0);
        chk("midcalc_frame_err", 32'(frame_err), 0);
        chk("midcalc_bank", 32'(display_bank), 0);
        chk("midcalc_cfg_ready", 32'(cfg_ready), 1);
        chk_counts("midcalc", cnt, ezero);
        reset = 1'b0; enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
